vending_change_dispenser: RTL and testbench
===========================================

# vending_change_dispenser

Coin-output engine for the soda vending machine. It takes a cents amount from the vending controller and issues coins one at a time to the coin-ejector mechanism over a valid/ready handshake, using the same 2-bit coin encoding as the coin-input path. It sits between the vending controller (refund/change requests) and the ejector solenoid driver. Coin selection is greedy, largest denomination first, and a programmable recovery gap follows each ejected coin.

## Interface
- `AMT_W`, default 8: width of the amount in cents; maximum request is 255.
- `GAP_CYCLES`, default 5: idle cycles after each accepted coin for solenoid recovery (50 ms at 100 Hz). A value of 0 means no gap.
- `CNT_W`, default 6: width of `coins_issued`.
- `clk`  in  1  100 Hz system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request strobe, sampled only in IDLE.
- `amount`  in  AMT_W  cents to return, sampled with `start`.
- `abort`  in  1  cancels the request in progress.
- `coin_ready`  in  1  ejector accepts the presented coin at this edge.
- `coin_valid`  out  1  a coin is presented on `coin_out`.
- `coin_out`  out  2  coin code: 00 = 5c, 01 = 10c, 10 = 25c, 11 = 100c.
- `busy`  out  1  a request is in progress (any state other than IDLE).
- `done`  out  1  one-cycle completion pulse.
- `error`  out  1  the last request was rejected because `amount` is not a multiple of 5.
- `coins_issued`  out  CNT_W  number of coins accepted for the current or last request.

## Operation
- Clock is `clk`. Reset is `reset`, asynchronous and active-high.
- Reset values: state IDLE; `coin_valid`, `busy`, `done` and `error` are 0; `coin_out` is 00; `coins_issued` is 0; `remaining` is 0.
- **IDLE**
  - On `start`=1: latch `remaining` = `amount`, clear `error` and `coins_issued`, go to CHECK.
  - Without `start`, stay in IDLE.
- **CHECK**
  - If `remaining` mod 5 ≠ 0: set `error`=1, go to DONE; no coin is issued.
  - Else if `remaining` = 0: go to DONE.
  - Otherwise, select the coin greedily:
    - `remaining` ≥ 100 → 11
    - `remaining` ≥ 25 → 10
    - `remaining` ≥ 10 → 01
    - otherwise → 00
  - Register the selected code on `coin_out`, set `coin_valid`=1, go to ISSUE.
- **ISSUE**
  - Hold `coin_valid` and `coin_out` stable until an edge where `coin_ready`=1.
  - At that edge: subtract the coin value from `remaining`, increment `coins_issued`, clear `coin_valid`.
  - Then go to GAP with the counter at `GAP_CYCLES`, or go straight to CHECK if `GAP_CYCLES` = 0.
- **GAP**
  - Decrement the counter each cycle.
  - Go to CHECK on the edge where the counter reaches 1, so GAP lasts exactly `GAP_CYCLES` cycles.
- **DONE**
  - `done`=1 for exactly one cycle, then go to IDLE.
- **`abort`**
  - In any state other than IDLE, `abort` takes priority over every other transition.
  - At that edge: clear `coin_valid` and `remaining`, go to IDLE.
  - No `done` pulse; `coins_issued` keeps its count.
- **`start` while not IDLE** is ignored, and `amount` is not re-sampled.
- **`coin_ready` while `coin_valid`=0** is ignored.
- **Arithmetic:** `remaining` never underflows, because greedy selection guarantees value ≤ `remaining`. `coins_issued` saturates at its maximum value and does not wrap.

## Timing
- `start` accepted at edge k:
  - `busy`=1 from edge k.
  - First `coin_valid`=1 from edge k+1.
- Zero or error request: `done` is high in the cycle after edge k+1, and `busy` drops one edge later.
- Each coin occupies:
  - the ISSUE cycles (at least 1, more under backpressure), then
  - `GAP_CYCLES` cycles of GAP, then
  - one cycle of CHECK before the next `coin_valid`.
- With `coin_ready` tied to 1, the coin pitch is `GAP_CYCLES`+2 cycles.
- `error` and `coins_issued` stay stable from DONE until the next accepted `start`.
- Reset mid-operation: all outputs return to their reset values immediately (asynchronous), and any coin presented at that moment is dropped.

## Test plan
- `amount`=70, `coin_ready`=1, `GAP_CYCLES`=5 → coins 10, 10, 01, 01 with a 7-cycle pitch; `coins_issued`=4; `done` pulses once; `error`=0.
- `amount`=185 → coins 11, 10, 10, 10, 01; `coins_issued`=5; `remaining` reaches 0.
- `amount`=0 → no `coin_valid`; `done` 2 cycles after `start`. `amount`=73 → `error`=1, no coins, `done` pulses.
- `amount`=35, `coin_ready` held low 10 cycles on the first coin → `coin_out`=10 and `coin_valid` stay stable for all 10 cycles; then 01 follows; total 2 coins.
- `amount`=200, `abort` during the GAP after the first coin → `busy`=0 next cycle, no `done`, `coins_issued`=1. A new `start` with `amount`=5 → single coin 00.
- Second `start` (`amount`=100) asserted while busy with `amount`=25 → ignored; only coin 10 is issued. Asynchronous `reset` asserted mid-ISSUE → all outputs return to 0 immediately.

Source files
------------

// File: rtl/vending_change_dispenser.sv
// Purpose: greedy coin-output engine; turns a cents amount into a sequence of 5/10/25/100c coins for the ejector.
// Latency: first coin presented 1 cycle after start is accepted; coin pitch is GAP_CYCLES+2 cycles with coin_ready held high.
// Backpressure: coin_valid/coin_out are held stable until coin_ready; abort cancels at once from any non-idle state.
module vending_change_dispenser #(
    parameter int AMT_W      = 8,
    parameter int GAP_CYCLES = 5,
    parameter int CNT_W      = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [AMT_W-1:0] amount,
    input  logic             abort,
    input  logic             coin_ready,
    output logic             coin_valid,
    output logic [1:0]       coin_out,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] coins_issued
);

    // Gap counter must hold GAP_CYCLES; keep at least one bit so GAP_CYCLES=0/1 still elaborate.
    localparam int GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);

    // Coin codes shared with the coin-input path.
    localparam logic [1:0] CODE_5   = 2'b00;
    localparam logic [1:0] CODE_10  = 2'b01;
    localparam logic [1:0] CODE_25  = 2'b10;
    localparam logic [1:0] CODE_100 = 2'b11;

    localparam logic [AMT_W-1:0] VAL_5   = AMT_W'(5);
    localparam logic [AMT_W-1:0] VAL_10  = AMT_W'(10);
    localparam logic [AMT_W-1:0] VAL_25  = AMT_W'(25);
    localparam logic [AMT_W-1:0] VAL_100 = AMT_W'(100);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ISSUE,
        S_GAP,
        S_DONE
    } state_t;

    state_t           state;
    logic [AMT_W-1:0] remaining;
    logic [GAP_W-1:0] gap_cnt;

    logic [1:0]       sel_code;
    logic [AMT_W-1:0] presented_val;
    logic             rem_bad;
    logic             rem_zero;

    // Greedy pick of the largest coin that fits in what is still owed.
    always_comb begin
        sel_code = CODE_5;
        if (remaining >= VAL_100) begin
            sel_code = CODE_100;
        end else if (remaining >= VAL_25) begin
            sel_code = CODE_25;
        end else if (remaining >= VAL_10) begin
            sel_code = CODE_10;
        end
    end

    // Value of the coin currently on coin_out, used to retire it from remaining on acceptance.
    always_comb begin
        presented_val = VAL_5;
        case (coin_out)
            CODE_10:  presented_val = VAL_10;
            CODE_25:  presented_val = VAL_25;
            CODE_100: presented_val = VAL_100;
            default:  presented_val = VAL_5;
        endcase
    end

    // Amounts that are not a multiple of 5c can never be paid out exactly.
    always_comb begin
        rem_bad  = (remaining % VAL_5) != '0;
        rem_zero = (remaining == '0);
    end

    // Request sequencer with registered outputs; abort overrides every other transition.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            remaining    <= '0;
            gap_cnt      <= '0;
            coin_valid   <= 1'b0;
            coin_out     <= CODE_5;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            coins_issued <= '0;
        end else if (abort && (state != S_IDLE)) begin
            // coins_issued and error are left alone so the controller can see how far it got.
            state      <= S_IDLE;
            remaining  <= '0;
            coin_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        remaining    <= amount;
                        error        <= 1'b0;
                        coins_issued <= '0;
                        busy         <= 1'b1;
                        state        <= S_CHECK;
                    end
                end

                S_CHECK: begin
                    if (rem_bad) begin
                        error <= 1'b1;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else if (rem_zero) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        coin_out   <= sel_code;
                        coin_valid <= 1'b1;
                        state      <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    // coin_out is only loaded in CHECK, so it stays stable across backpressure.
                    if (coin_valid && coin_ready) begin
                        // Greedy selection guarantees presented_val <= remaining, so no underflow.
                        remaining  <= remaining - presented_val;
                        coin_valid <= 1'b0;
                        if (coins_issued != '1) begin
                            coins_issued <= coins_issued + CNT_W'(1);
                        end
                        if (GAP_CYCLES == 0) begin
                            state <= S_CHECK;
                        end else begin
                            gap_cnt <= GAP_W'(GAP_CYCLES);
                            state   <= S_GAP;
                        end
                    end
                end

                S_GAP: begin
                    // Leaving on the count of 1 makes the gap exactly GAP_CYCLES cycles long.
                    gap_cnt <= gap_cnt - GAP_W'(1);
                    if (gap_cnt <= GAP_W'(1)) begin
                        state <= S_CHECK;
                    end
                end

                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    state      <= S_IDLE;
                    coin_valid <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vending_change_dispenser.sv
// Bench for vending_change_dispenser: expected coin codes are queued when a request is
// started and popped by a monitor on every accepted coin; each scenario task checks its
// own timing, counts and flags inline.
module tb_vending_change_dispenser;

    localparam int AMT_W      = 8;
    localparam int GAP_CYCLES = 5;
    localparam int CNT_W      = 6;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [AMT_W-1:0] amount;
    logic             abort;
    logic             coin_ready;
    logic             coin_valid;
    logic [1:0]       coin_out;
    logic             busy;
    logic             done;
    logic             error;
    logic [CNT_W-1:0] coins_issued;

    vending_change_dispenser #(
        .AMT_W     (AMT_W),
        .GAP_CYCLES(GAP_CYCLES),
        .CNT_W     (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .amount      (amount),
        .abort       (abort),
        .coin_ready  (coin_ready),
        .coin_valid  (coin_valid),
        .coin_out    (coin_out),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .coins_issued(coins_issued)
    );

    always #5 clk = ~clk;

    int         errors   = 0;
    int         checks   = 0;
    int         cyc      = 0;
    int         done_cnt = 0;
    logic [1:0] exp_q[$];
    int         acc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: a coin shown with coin_ready high is taken at the next rising edge.
    always @(negedge clk) begin
        logic [1:0] exp_code;
        if (!reset && done) done_cnt++;
        if (!reset && coin_valid && coin_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL coin_unexpected: got code %0d, expected no coin", coin_out);
            end else begin
                exp_code = exp_q.pop_front();
                if (coin_out !== exp_code) begin
                    errors++;
                    $display("FAIL coin_code: got %0d, expected %0d", coin_out, exp_code);
                end
            end
            acc_q.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int a);
        amount = AMT_W'(a);
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic wait_done(output bit timed_out);
        int n;
        n = 0;
        timed_out = 1'b0;
        while (done !== 1'b1) begin
            tick();
            n++;
            if (n > 3000) begin
                timed_out = 1'b1;
                break;
            end
        end
    endtask

    task automatic clear_sb();
        exp_q.delete();
        acc_q.delete();
        done_cnt = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        checks++;
        if ({coin_valid, coin_out, busy, done, error, coins_issued} !== '0) begin
            errors++;
            $display("FAIL reset_state: got v=%b c=%b b=%b d=%b e=%b n=%0d, expected all 0",
                     coin_valid, coin_out, busy, done, error, coins_issued);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_amount_70();
        bit to;
        clear_sb();
        coin_ready = 1'b1;
        exp_q = '{2'b10, 2'b10, 2'b01, 2'b01};
        do_start(70);
        checks++;
        if (busy !== 1'b1 || coin_valid !== 1'b0) begin
            errors++;
            $display("FAIL start_edge70: got busy=%b valid=%b, expected busy=1 valid=0", busy, coin_valid);
        end
        tick();
        checks++;
        if (coin_valid !== 1'b1) begin
            errors++;
            $display("FAIL first_valid70: got %b, expected 1", coin_valid);
        end
        wait_done(to);
        checks++;
        if (to) begin errors++; $display("FAIL done_timeout70: got no done, expected done"); end
        checks++;
        if (coins_issued !== CNT_W'(4) || error !== 1'b0) begin
            errors++;
            $display("FAIL count70: got n=%0d err=%b, expected n=4 err=0", coins_issued, error);
        end
        for (int i = 1; i < acc_q.size(); i++) begin
            checks++;
            if (acc_q[i] - acc_q[i-1] !== GAP_CYCLES + 2) begin
                errors++;
                $display("FAIL pitch70: got %0d, expected %0d", acc_q[i] - acc_q[i-1], GAP_CYCLES + 2);
            end
        end
        tick();
        tick();
        checks++;
        if (done_cnt !== 1 || busy !== 1'b0 || exp_q.size() !== 0 || acc_q.size() !== 4) begin
            errors++;
            $display("FAIL tail70: got pulses=%0d busy=%b left=%0d coins=%0d, expected 1 0 0 4",
                     done_cnt, busy, exp_q.size(), acc_q.size());
        end
    endtask

    task automatic test_amount_185();
        bit to;
        clear_sb();
        coin_ready = 1'b1;
        exp_q = '{2'b11, 2'b10, 2'b10, 2'b10, 2'b01};
        do_start(185);
        wait_done(to);
        checks++;
        if (to || coins_issued !== CNT_W'(5) || error !== 1'b0 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL amount185: got to=%b n=%0d err=%b left=%0d, expected to=0 n=5 err=0 left=0",
                     to, coins_issued, error, exp_q.size());
        end
        tick();
    endtask

    task automatic test_zero_and_error();
        bit to;
        clear_sb();
        coin_ready = 1'b1;
        do_start(0);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL zero_early_done: got %b, expected 0", done); end
        tick();
        checks++;
        if (done !== 1'b1 || coin_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_done: got done=%b valid=%b, expected done=1 valid=0", done, coin_valid);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
            errors++;
            $display("FAIL zero_tail: got busy=%b done=%b err=%b, expected 0 0 0", busy, done, error);
        end
        do_start(73);
        wait_done(to);
        tick();
        tick();
        tick();
        checks++;
        if (to || error !== 1'b1 || coins_issued !== '0 || acc_q.size() !== 0 || done_cnt !== 2) begin
            errors++;
            $display("FAIL err73: got to=%b err=%b n=%0d coins=%0d pulses=%0d, expected 0 1 0 0 2",
                     to, error, coins_issued, acc_q.size(), done_cnt);
        end
    endtask

    task automatic test_backpressure();
        bit to;
        bit stable;
        clear_sb();
        coin_ready = 1'b0;
        exp_q = '{2'b10, 2'b01};
        do_start(35);
        tick();
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (coin_valid !== 1'b1 || coin_out !== 2'b10) stable = 1'b0;
            tick();
        end
        checks++;
        if (stable !== 1'b1) begin
            errors++;
            $display("FAIL hold35: got unstable coin (v=%b c=%b), expected valid=1 code=2 held", coin_valid, coin_out);
        end
        coin_ready = 1'b1;
        wait_done(to);
        checks++;
        if (to || coins_issued !== CNT_W'(2) || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL count35: got to=%b n=%0d left=%0d, expected 0 2 0", to, coins_issued, exp_q.size());
        end
        tick();
    endtask

    task automatic test_abort();
        bit to;
        clear_sb();
        coin_ready = 1'b1;
        exp_q = '{2'b11};
        do_start(200);
        tick();
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || coin_valid !== 1'b0 || coins_issued !== CNT_W'(1)) begin
            errors++;
            $display("FAIL abort200: got busy=%b valid=%b n=%0d, expected 0 0 1", busy, coin_valid, coins_issued);
        end
        for (int i = 0; i < 12; i++) tick();
        checks++;
        if (done_cnt !== 0 || acc_q.size() !== 1) begin
            errors++;
            $display("FAIL abort_quiet: got pulses=%0d coins=%0d, expected 0 1", done_cnt, acc_q.size());
        end
        exp_q = '{2'b00};
        do_start(5);
        wait_done(to);
        checks++;
        if (to || coins_issued !== CNT_W'(1) || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL after_abort5: got to=%b n=%0d left=%0d, expected 0 1 0", to, coins_issued, exp_q.size());
        end
        tick();
    endtask

    task automatic test_ignore_start();
        bit to;
        clear_sb();
        coin_ready = 1'b0;
        exp_q = '{2'b10};
        do_start(25);
        amount = AMT_W'(100);
        start  = 1'b1;
        tick();
        start  = 1'b0;
        checks++;
        if (coin_valid !== 1'b1 || coin_out !== 2'b10) begin
            errors++;
            $display("FAIL ignore_start: got v=%b c=%0d, expected v=1 c=2", coin_valid, coin_out);
        end
        coin_ready = 1'b1;
        wait_done(to);
        checks++;
        if (to || coins_issued !== CNT_W'(1) || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL ignore_count: got to=%b n=%0d left=%0d, expected 0 1 0", to, coins_issued, exp_q.size());
        end
        tick();
    endtask

    task automatic test_reset_mid_issue();
        clear_sb();
        coin_ready = 1'b0;
        do_start(10);
        tick();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({coin_valid, coin_out, busy, done, error, coins_issued} !== '0) begin
            errors++;
            $display("FAIL async_reset: got v=%b c=%b b=%b d=%b e=%b n=%0d, expected all 0",
                     coin_valid, coin_out, busy, done, error, coins_issued);
        end
        tick();
        reset = 1'b0;
        coin_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || acc_q.size() !== 0) begin
            errors++;
            $display("FAIL post_reset: got busy=%b coins=%0d, expected 0 0", busy, acc_q.size());
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        int amts[4] = '{255, 140, 45, 15};
        int rem;
        int n;
        coin_ready = 1'b1;
        foreach (amts[k]) begin
            clear_sb();
            rem = amts[k];
            n = 0;
            while (rem > 0) begin
                if (rem >= 100) begin exp_q.push_back(2'b11); rem -= 100; end
                else if (rem >= 25) begin exp_q.push_back(2'b10); rem -= 25; end
                else if (rem >= 10) begin exp_q.push_back(2'b01); rem -= 10; end
                else begin exp_q.push_back(2'b00); rem -= 5; end
                n++;
            end
            do_start(amts[k]);
            wait_done(to);
            checks++;
            if (to || coins_issued !== CNT_W'(n) || exp_q.size() !== 0 || error !== 1'b0) begin
                errors++;
                $display("FAIL b2b_%0d: got to=%b n=%0d left=%0d err=%b, expected 0 %0d 0 0",
                         amts[k], to, coins_issued, exp_q.size(), error, n);
            end
            tick();
        end
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        amount     = '0;
        abort      = 1'b0;
        coin_ready = 1'b0;
        test_reset();
        test_amount_70();
        test_amount_185();
        test_zero_and_error();
        test_backpressure();
        test_abort();
        test_ignore_start();
        test_reset_mid_issue();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
